l2_port_arbiter: RTL

- Two-requester arbiter that shares the single L2 cache port between the L1 I-cache (read-only) and the L1 D-cache (read/write).
- Sits between the two L1 caches and the L2 cache; its downstream side drives L2, which in turn feeds the eviction write buffer and physical memory.
- Grants one requester at a time, locks the grant until L2 responds, and routes the response back to the granted requester only.

---
 rtl/l2_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 port between the read-only L1 I-cache
// and the read/write L1 D-cache.
//
// One grant register selects the current owner. The grant is held until L2
// answers or the owner drops its request. The response is routed back to the
// owner only. The arbiter does not buffer any data: the address, write data
// and read data pass straight through, steered by the grant.
//
// Build option: define L2_ARB_ROUND_ROBIN_EN to make contention alternate
// between the requesters. When the macro is undefined, the D-cache always
// wins contention. Single-requester behaviour is the same in both builds.
module l2_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic                  icache_read,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    state_t state_reg;
    owner_t last_grant_reg;

    logic i_req;
    logic d_req;
    logic rr_pick_d;
    logic d_wins;

    assign i_req     = icache_read;
    assign d_req     = dcache_read | dcache_write;
    assign rr_pick_d = (last_grant_reg == OWNER_I);

    // Decide who wins when both requesters ask in the same IDLE cycle.
    always_comb begin
        d_wins = 1'b1;
`ifdef L2_ARB_ROUND_ROBIN_EN
        // Serve the requester that was not served last; last_grant resets to
        // the I-cache, so the D-cache wins the first contention.
        d_wins = rr_pick_d;
`else
        // Fixed priority: the D-cache always wins. last_grant is still
        // tracked so that both builds keep the same state.
        d_wins = rr_pick_d | 1'b1;
`endif
    end

    // Grant FSM: a registered arbitration decision; the grant is released on
    // the L2 response or when the owner abandons its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= OWNER_I;
        end else begin
            case (state_reg)
                IDLE: begin
                    // l2_resp is ignored here; nobody owns the port.
                    if (i_req && d_req)
                        state_reg <= d_wins ? GRANT_D : GRANT_I;
                    else if (i_req)
                        state_reg <= GRANT_I;
                    else if (d_req)
                        state_reg <= GRANT_D;
                end
                GRANT_I: begin
                    if (l2_resp) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= OWNER_I;
                    end else if (!i_req) begin
                        // The owner aborted: release the grant but keep last_grant.
                        state_reg <= IDLE;
                    end
                end
                GRANT_D: begin
                    if (l2_resp) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= OWNER_D;
                    end else if (!d_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Steer the L2 port and the responses from the grant. Because this logic
    // is combinational on state_reg, an asynchronous reset drops the strobes
    // at once.
    always_comb begin
        l2_addr      = '0;
        l2_wdata     = '0;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        // Read data fans out to both requesters; each one must qualify it
        // with its own resp.
        icache_rdata = l2_rdata;
        dcache_rdata = l2_rdata;
        case (state_reg)
            GRANT_I: begin
                l2_addr     = icache_addr;
                l2_read     = icache_read;
                icache_resp = l2_resp;
            end
            GRANT_D: begin
                l2_addr     = dcache_addr;
                l2_wdata    = dcache_wdata;
                // Read and write together is illegal; the write takes precedence.
                l2_read     = dcache_read & ~dcache_write;
                l2_write    = dcache_write;
                dcache_resp = l2_resp;
            end
            default: ;
        endcase
    end

endmodule
